// File: rtl/fft_out_scaler.sv
// fft_out_scaler: output stage of the 256-point fixed-point FFT core.
// Rounds (half-up), shifts and saturates each 32-bit complex component to
// P_OUT_WIDTH bits, packs {im, re} into one word, regenerates frame framing
// from an internal sample counter and keeps frame/saturation statistics.
//
// Ports:
//   aclk, areset            clock, synchronous active-high reset
//   s_axis_*                64-bit complex input stream ([31:0]=re, [63:32]=im)
//   m_axis_*                packed output stream, tuser = sample index [7:0]
//   clear                   synchronous clear of frame_count / sat_count
//   frame_count             completed frames (wraps)
//   sat_count               beats with any clipped component (sticks at max)
//   err_tlast_missing       pulse: no tlast on the last sample of a frame
//   err_tlast_unexpected    pulse: tlast before the last sample of a frame
module fft_out_scaler #(
  parameter int unsigned P_SAMPLE_NUM = 256,
  parameter int unsigned P_SHIFT      = 8,
  parameter int unsigned P_OUT_WIDTH  = 16
) (
  input  logic                       aclk,
  input  logic                       areset,
  input  logic [63:0]                s_axis_tdata,
  input  logic                       s_axis_tvalid,
  output logic                       s_axis_tready,
  input  logic                       s_axis_tlast,
  output logic [2*P_OUT_WIDTH-1:0]   m_axis_tdata,
  output logic [7:0]                 m_axis_tuser,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic                       m_axis_tlast,
  input  logic                       clear,
  output logic [15:0]                frame_count,
  output logic [15:0]                sat_count,
  output logic                       err_tlast_missing,
  output logic                       err_tlast_unexpected
);

  localparam int unsigned IdxW = (P_SAMPLE_NUM > 1) ? $clog2(P_SAMPLE_NUM) : 1;
  localparam int unsigned DW   = 2 * P_OUT_WIDTH;

  localparam logic signed [32:0] MaxPos = (33'sd1 <<< (P_OUT_WIDTH - 1)) - 33'sd1;
  localparam logic signed [32:0] MaxNeg = -(33'sd1 <<< (P_OUT_WIDTH - 1));
  localparam logic signed [32:0] Half   = 33'sd1 <<< (P_SHIFT - 1);

  // Returns {clipped, value}.
  function automatic logic [P_OUT_WIDTH:0] scale_comp(input logic [31:0] x);
    logic signed [32:0] t;
    logic signed [32:0] y;
    t = $signed({x[31], x}) + Half;
    y = t >>> P_SHIFT;
    if (y > MaxPos) begin
      scale_comp = {1'b1, MaxPos[P_OUT_WIDTH-1:0]};
    end else if (y < MaxNeg) begin
      scale_comp = {1'b1, MaxNeg[P_OUT_WIDTH-1:0]};
    end else begin
      scale_comp = {1'b0, y[P_OUT_WIDTH-1:0]};
    end
  endfunction

  // Two-entry buffer: head drives the output port directly, tail holds the overflow beat.
  logic [DW-1:0]   head_data_q, head_data_d, tail_data_q, tail_data_d;
  logic [7:0]      head_user_q, head_user_d, tail_user_q, tail_user_d;
  logic            head_last_q, head_last_d, tail_last_q, tail_last_d;
  logic [1:0]      count_q, count_d;
  logic            ready_q, ready_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [15:0]     frame_q, frame_d, sat_q, sat_d;
  logic            err_miss_q, err_miss_d, err_unexp_q, err_unexp_d;

  logic                 in_fire, out_fire;
  logic [P_OUT_WIDTH:0] re_s, im_s;
  logic [DW-1:0]        beat_data;
  logic [7:0]           beat_user;
  logic                 beat_sat, at_end, beat_last;

  always_comb begin
    in_fire   = s_axis_tvalid & ready_q;
    out_fire  = (count_q != 2'd0) & m_axis_tready;
    re_s      = scale_comp(s_axis_tdata[31:0]);
    im_s      = scale_comp(s_axis_tdata[63:32]);
    beat_data = {im_s[P_OUT_WIDTH-1:0], re_s[P_OUT_WIDTH-1:0]};
    beat_sat  = re_s[P_OUT_WIDTH] | im_s[P_OUT_WIDTH];
    beat_user = 8'(idx_q);
    at_end    = (idx_q == IdxW'(P_SAMPLE_NUM - 1));
    beat_last = at_end | s_axis_tlast;

    head_data_d = head_data_q;
    head_user_d = head_user_q;
    head_last_d = head_last_q;
    tail_data_d = tail_data_q;
    tail_user_d = tail_user_q;
    tail_last_d = tail_last_q;
    count_d     = count_q;

    unique case (count_q)
      2'd0: begin
        if (in_fire) begin
          head_data_d = beat_data;
          head_user_d = beat_user;
          head_last_d = beat_last;
          count_d     = 2'd1;
        end
      end
      2'd1: begin
        if (in_fire && out_fire) begin
          head_data_d = beat_data;
          head_user_d = beat_user;
          head_last_d = beat_last;
        end else if (in_fire) begin
          tail_data_d = beat_data;
          tail_user_d = beat_user;
          tail_last_d = beat_last;
          count_d     = 2'd2;
        end else if (out_fire) begin
          count_d = 2'd0;
        end
      end
      2'd2: begin
        // No push possible here: ready is low while full.
        if (out_fire) begin
          head_data_d = tail_data_q;
          head_user_d = tail_user_q;
          head_last_d = tail_last_q;
          count_d     = 2'd1;
        end
      end
      default: count_d = 2'd0;
    endcase

    // Ready is registered from the next occupancy, so m_axis_tready never reaches it combinationally.
    ready_d = (count_d != 2'd2);

    idx_d = idx_q;
    if (in_fire) begin
      idx_d = beat_last ? '0 : idx_q + 1'b1;
    end

    err_unexp_d = in_fire & s_axis_tlast & ~at_end;
    err_miss_d  = in_fire & ~s_axis_tlast & at_end;

    frame_d = frame_q;
    sat_d   = sat_q;
    if (clear) begin
      frame_d = '0;
      sat_d   = '0;
    end else begin
      if (in_fire && beat_last) begin
        frame_d = frame_q + 16'd1;
      end
      if (in_fire && beat_sat && (sat_q != 16'hFFFF)) begin
        sat_d = sat_q + 16'd1;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      head_data_q <= '0;
      head_user_q <= '0;
      head_last_q <= 1'b0;
      tail_data_q <= '0;
      tail_user_q <= '0;
      tail_last_q <= 1'b0;
      count_q     <= 2'd0;
      ready_q     <= 1'b0;
      idx_q       <= '0;
      frame_q     <= '0;
      sat_q       <= '0;
      err_miss_q  <= 1'b0;
      err_unexp_q <= 1'b0;
    end else begin
      head_data_q <= head_data_d;
      head_user_q <= head_user_d;
      head_last_q <= head_last_d;
      tail_data_q <= tail_data_d;
      tail_user_q <= tail_user_d;
      tail_last_q <= tail_last_d;
      count_q     <= count_d;
      ready_q     <= ready_d;
      idx_q       <= idx_d;
      frame_q     <= frame_d;
      sat_q       <= sat_d;
      err_miss_q  <= err_miss_d;
      err_unexp_q <= err_unexp_d;
    end
  end

  assign s_axis_tready        = ready_q;
  assign m_axis_tdata         = head_data_q;
  assign m_axis_tuser         = head_user_q;
  assign m_axis_tlast         = head_last_q;
  assign m_axis_tvalid        = (count_q != 2'd0);
  assign frame_count          = frame_q;
  assign sat_count            = sat_q;
  assign err_tlast_missing    = err_miss_q;
  assign err_tlast_unexpected = err_unexp_q;

endmodule

// File: tb/tb_fft_out_scaler.sv
// Testbench for fft_out_scaler: directed scenarios plus a randomized phase,
// all checked against a transaction-level model (queue of expected beats,
// sample index, counters) computed with plain integer arithmetic.
module tb_fft_out_scaler;

  localparam int N  = 256;
  localparam int SH = 8;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic [63:0] s_axis_tdata = '0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic        s_axis_tlast = 1'b0;
  logic [31:0] m_axis_tdata;
  logic [7:0]  m_axis_tuser;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b0;
  logic        m_axis_tlast;
  logic        clear = 1'b0;
  logic [15:0] frame_count;
  logic [15:0] sat_count;
  logic        err_tlast_missing;
  logic        err_tlast_unexpected;

  fft_out_scaler #(
    .P_SAMPLE_NUM(N),
    .P_SHIFT     (SH),
    .P_OUT_WIDTH (16)
  ) dut (
    .aclk                (aclk),
    .areset              (areset),
    .s_axis_tdata        (s_axis_tdata),
    .s_axis_tvalid       (s_axis_tvalid),
    .s_axis_tready       (s_axis_tready),
    .s_axis_tlast        (s_axis_tlast),
    .m_axis_tdata        (m_axis_tdata),
    .m_axis_tuser        (m_axis_tuser),
    .m_axis_tvalid       (m_axis_tvalid),
    .m_axis_tready       (m_axis_tready),
    .m_axis_tlast        (m_axis_tlast),
    .clear               (clear),
    .frame_count         (frame_count),
    .sat_count           (sat_count),
    .err_tlast_missing   (err_tlast_missing),
    .err_tlast_unexpected(err_tlast_unexpected)
  );

  always #5 aclk = ~aclk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not end within time limit");
    $fatal(1);
  end

  typedef struct {
    logic [31:0] data;
    logic [7:0]  user;
    logic        last;
  } beat_t;

  beat_t exp_q[$];
  int    m_idx;
  int    m_frames;
  int    m_sats;
  bit    m_eu;
  bit    m_em;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Round-half-up divide by 2^SH using floor division, then clip to 16 bits.
  function automatic logic [15:0] ref_comp(input logic [31:0] x, output bit sat);
    longint v, d, t, y;
    v = longint'($signed(x));
    d = longint'(1) << SH;
    t = v + d / 2;
    if (t >= 0) y = t / d;
    else        y = -((-t + d - 1) / d);
    sat = 1'b0;
    if (y > 32767) begin
      sat = 1'b1;
      return 16'h7FFF;
    end else if (y < -32768) begin
      sat = 1'b1;
      return 16'h8000;
    end
    return 16'(y);
  endfunction

  function automatic logic [31:0] rand_comp();
    int unsigned r;
    r = $urandom % 5;
    case (r)
      0: return $urandom;
      1: return 32'($signed($urandom) >>> ($urandom % 24 + 8));
      2: return 32'(32767 * 256 + int'($urandom % 512) - 256);
      3: return 32'(-32768 * 256 + int'($urandom % 512) - 256);
      default: return ($urandom % 2) ? 32'h7FFF_FFFF : 32'h8000_0000;
    endcase
  endfunction

  task automatic model_clear();
    exp_q.delete();
    m_idx    = 0;
    m_frames = 0;
    m_sats   = 0;
    m_eu     = 1'b0;
    m_em     = 1'b0;
  endtask

  // One clock cycle: drive inputs at the falling edge, check outputs, advance the model.
  task automatic step(input logic vld, input logic [63:0] data, input logic last,
                      input logic mrdy, input logic clr, output bit fired);
    bit          sr, si, eu_n, em_n, tl;
    logic [15:0] re, im;
    beat_t       b;
    int          occ;
    @(negedge aclk);
    s_axis_tvalid = vld;
    s_axis_tdata  = data;
    s_axis_tlast  = last;
    m_axis_tready = mrdy;
    clear         = clr;
    occ = exp_q.size();
    check("s_tready", s_axis_tready, occ < 2);
    check("m_tvalid", m_axis_tvalid, occ != 0);
    if (occ != 0) begin
      check("m_tdata", m_axis_tdata, exp_q[0].data);
      check("m_tuser", m_axis_tuser, exp_q[0].user);
      check("m_tlast", m_axis_tlast, exp_q[0].last);
    end
    check("err_unexpected", err_tlast_unexpected, m_eu);
    check("err_missing", err_tlast_missing, m_em);
    check("frame_count", frame_count, m_frames);
    check("sat_count", sat_count, m_sats);

    fired = vld && (occ < 2);
    eu_n = 1'b0;
    em_n = 1'b0;
    if (mrdy && occ != 0) void'(exp_q.pop_front());
    if (fired) begin
      re = ref_comp(data[31:0], sr);
      im = ref_comp(data[63:32], si);
      tl = (m_idx == N - 1) || last;
      b.data = {im, re};
      b.user = 8'(m_idx);
      b.last = tl;
      exp_q.push_back(b);
      eu_n = last && (m_idx != N - 1);
      em_n = !last && (m_idx == N - 1);
      m_idx = tl ? 0 : m_idx + 1;
      if (tl) m_frames = (m_frames + 1) % 65536;
      if ((sr || si) && m_sats < 65535) m_sats++;
    end
    if (clr) begin
      m_frames = 0;
      m_sats   = 0;
    end
    m_eu = eu_n;
    m_em = em_n;
  endtask

  task automatic do_reset();
    @(negedge aclk);
    areset        = 1'b1;
    s_axis_tvalid = 1'b0;
    clear         = 1'b0;
    @(negedge aclk);
    check("rst_s_tready", s_axis_tready, 1'b0);
    check("rst_m_tvalid", m_axis_tvalid, 1'b0);
    check("rst_m_tdata", m_axis_tdata, 32'h0);
    check("rst_m_tuser", m_axis_tuser, 8'h0);
    check("rst_m_tlast", m_axis_tlast, 1'b0);
    check("rst_frame_count", frame_count, 16'h0);
    check("rst_sat_count", sat_count, 16'h0);
    check("rst_errs", {err_tlast_missing, err_tlast_unexpected}, 2'b00);
    areset = 1'b0;
    model_clear();
  endtask

  initial begin
    bit          f;
    int          acc;
    int          k;
    logic [63:0] bp[3];

    model_clear();
    do_reset();

    // Single beat, one-cycle latency.
    step(1'b1, {32'hFFFF_FF80, 32'h0000_1234}, 1'b0, 1'b1, 1'b0, f);
    step(1'b0, 64'h0, 1'b0, 1'b1, 1'b0, f);
    check("single_data", m_axis_tdata, 32'h0000_0012);
    check("single_user", m_axis_tuser, 8'h00);
    check("single_sat", sat_count, 16'h0);

    // Saturation in both directions, then clear.
    step(1'b1, {32'h8000_0000, 32'h0100_0000}, 1'b0, 1'b1, 1'b0, f);
    step(1'b0, 64'h0, 1'b0, 1'b1, 1'b0, f);
    check("sat_data", m_axis_tdata, 32'h8000_7FFF);
    check("sat_count_1", sat_count, 16'd1);
    step(1'b0, 64'h0, 1'b0, 1'b1, 1'b1, f);
    step(1'b0, 64'h0, 1'b0, 1'b1, 1'b0, f);
    check("sat_cleared", sat_count, 16'd0);

    // Full frame at full throughput.
    do_reset();
    for (int i = 0; i < N; i++) begin
      step(1'b1, {32'(i), 32'(i)}, i == N - 1, 1'b1, 1'b0, f);
      check("frame_accept", f, 1'b1);
    end
    step(1'b0, 64'h0, 1'b0, 1'b1, 1'b0, f);
    step(1'b0, 64'h0, 1'b0, 1'b1, 1'b0, f);
    check("frame_count_1", frame_count, 16'd1);

    // Backpressure: 3 beats offered while output stalled.
    bp[0] = {32'h0000_0100, 32'h0000_0200};
    bp[1] = {32'hFFFF_FE00, 32'h0000_0A80};
    bp[2] = {32'h0012_3400, 32'hFFED_CC00};
    acc = 0;
    for (int c = 0; c < 6; c++) begin
      step(acc < 3, bp[acc < 3 ? acc : 2], 1'b0, 1'b0, 1'b0, f);
      if (f) acc++;
    end
    check("bp_accepted", acc, 2);
    check("bp_tready_low", s_axis_tready, 1'b0);
    k = 0;
    while (acc < 3 && k < 10) begin
      step(1'b1, bp[acc], 1'b0, 1'b1, 1'b0, f);
      if (f) acc++;
      k++;
    end
    check("bp_all_in", acc, 3);
    for (int c = 0; c < 4; c++) step(1'b0, 64'h0, 1'b0, 1'b1, 1'b0, f);
    check("bp_drained", m_axis_tvalid, 1'b0);

    // Framing errors: early tlast at 99, then missing tlast at 255.
    do_reset();
    for (int i = 0; i < 100; i++) step(1'b1, {32'(i * 3), 32'(i)}, i == 99, 1'b1, 1'b0, f);
    step(1'b0, 64'h0, 1'b0, 1'b1, 1'b0, f);
    check("early_tlast_pulse", err_tlast_unexpected, 1'b1);
    for (int i = 0; i < N; i++) step(1'b1, {32'(i), 32'(-i)}, 1'b0, 1'b1, 1'b0, f);
    step(1'b0, 64'h0, 1'b0, 1'b1, 1'b0, f);
    check("missing_tlast_pulse", err_tlast_missing, 1'b1);
    step(1'b0, 64'h0, 1'b0, 1'b1, 1'b0, f);
    check("frame_count_2", frame_count, 16'd2);

    // Randomized traffic with random backpressure, stray tlast and clears.
    for (int c = 0; c < 3000; c++) begin
      step(($urandom % 4) != 0, {rand_comp(), rand_comp()}, ($urandom % 64) == 0,
           ($urandom % 3) != 0, ($urandom % 200) == 0, f);
    end
    for (int c = 0; c < 4; c++) step(1'b0, 64'h0, 1'b0, 1'b1, 1'b0, f);

    // Reset mid-frame with a beat buffered.
    do_reset();
    for (int i = 0; i < 40; i++) step(1'b1, {rand_comp(), rand_comp()}, 1'b0, 1'b1, 1'b0, f);
    step(1'b0, 64'h0, 1'b0, 1'b0, 1'b0, f);
    check("pre_reset_buffered", m_axis_tvalid, 1'b1);
    do_reset();
    step(1'b1, {32'h0000_0400, 32'h0000_0300}, 1'b0, 1'b1, 1'b0, f);
    step(1'b0, 64'h0, 1'b0, 1'b1, 1'b0, f);
    check("post_reset_user", m_axis_tuser, 8'h00);
    step(1'b0, 64'h0, 1'b0, 1'b1, 1'b0, f);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
